rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 64-bit, 32-entry register file. Shares the register file's single write port between NREQ write-back sources (ALU, load unit, multi-cycle unit) using round-robin arbitration with a registered commit stage. Tracks pending destination registers so the decode stage can stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file write port.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, register count and the write-back payload.
package rf_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot mask selecting a single architectural register.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    return NREG'(1) << r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, emits one-hot grant and
// the pointer just past the winner (ptr unchanged when nothing is requested).
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((32'(idx) + 32'd1) % N);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 32-entry register file.
// Optional RF_WB_BYPASS_EN forwards the committing write to decode source reads.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        wb_valid,
  output logic [NREQ-1:0]        wb_ready,
  input  logic [NREQ*REG_AW-1:0] wb_rd,
  input  logic [NREQ*XLEN-1:0]   wb_data,
  output logic                   rf_en_write,
  output logic [REG_AW-1:0]      rf_reg_w,
  output logic [XLEN-1:0]        rf_data_in,
  input  logic                   iss_valid,
  input  logic [REG_AW-1:0]      iss_rd,
  output logic                   iss_ready,
  input  logic [REG_AW-1:0]      rs1,
  input  logic [REG_AW-1:0]      rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   byp1_hit,
  output logic                   byp2_hit,
  output logic [XLEN-1:0]        byp1_data,
  output logic [XLEN-1:0]        byp2_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_ptr_nxt;
  logic [NREQ-1:0] gnt;
  logic            any_gnt;
  logic            commit_wr;
  wb_req_t         sel_req;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req      (wb_valid),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .next_ptr (rr_ptr_nxt)
  );

  assign wb_ready = gnt;
  assign any_gnt  = |gnt;

  // Mux the granted requester's payload.
  always_comb begin
    sel_req = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_req.rd   = wb_rd[k*REG_AW +: REG_AW];
        sel_req.data = wb_data[k*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are accepted but never reach the register file.
  assign commit_wr = any_gnt && (sel_req.rd != '0);

  // Pointer and commit stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      rf_en_write <= 1'b0;
      rf_reg_w    <= '0;
      rf_data_in  <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      rf_en_write <= commit_wr;
      if (commit_wr) begin
        rf_reg_w   <= sel_req.rd;
        rf_data_in <= sel_req.data;
      end
    end
  end

  assign iss_ready = (iss_rd == '0) || !busy[iss_rd];

  // Clear on commit first so a same-cycle issue to that register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (rf_en_write) begin
      busy_nxt = busy_nxt & ~reg_onehot(rf_reg_w);
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      busy_nxt = busy_nxt | reg_onehot(iss_rd);
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Source-operand status, optionally forwarding the write in flight.
  always_comb begin
    rs1_busy  = busy[rs1];
    rs2_busy  = busy[rs2];
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
`ifdef RF_WB_BYPASS_EN
    if (rf_en_write && (rf_reg_w == rs1)) begin
      byp1_hit  = 1'b1;
      byp1_data = rf_data_in;
      rs1_busy  = 1'b0;
    end
    if (rf_en_write && (rf_reg_w == rs2)) begin
      byp2_hit  = 1'b1;
      byp2_data = rf_data_in;
      rs2_busy  = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: expected commits queued at grant time, checked by a commit monitor.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned NREQ = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        wb_valid = '0;
  logic [NREQ-1:0]        wb_ready;
  logic [NREQ*REG_AW-1:0] wb_rd = '0;
  logic [NREQ*XLEN-1:0]   wb_data = '0;
  logic                   rf_en_write;
  logic [REG_AW-1:0]      rf_reg_w;
  logic [XLEN-1:0]        rf_data_in;
  logic                   iss_valid = 1'b0;
  logic [REG_AW-1:0]      iss_rd = '0;
  logic                   iss_ready;
  logic [REG_AW-1:0]      rs1 = '0;
  logic [REG_AW-1:0]      rs2 = '0;
  logic                   rs1_busy, rs2_busy, byp1_hit, byp2_hit;
  logic [XLEN-1:0]        byp1_data, byp2_data;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    int                cyc;
  } exp_t;
  exp_t sb[$];

  rf_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_en_write(rf_en_write), .rf_reg_w(rf_reg_w), .rf_data_in(rf_data_in),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Every register-file write must match the oldest queued expectation, in the expected cycle.
  always @(negedge clk) begin
    if (rst_n && rf_en_write) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected got rd=%0d data=%h want no write", rf_reg_w, rf_data_in);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rf_reg_w !== e.rd || rf_data_in !== e.data || cyc_cnt != e.cyc) begin
          errors++;
          $display("FAIL commit got rd=%0d data=%h cyc=%0d want rd=%0d data=%h cyc=%0d",
                   rf_reg_w, rf_data_in, cyc_cnt, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid  = '0;
    iss_valid = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    wb_valid[k]               = 1'b1;
    wb_rd[k*REG_AW +: REG_AW] = rd;
    wb_data[k*XLEN +: XLEN]   = d;
  endtask

  // Queue the commit expected one cycle after a grant driven in the current cycle.
  task automatic sb_push(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    exp_t e;
    if (rd != '0) begin
      e.rd = rd; e.data = d; e.cyc = cyc_cnt + 1;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_en_write, rf_reg_w, byp1_hit, byp2_hit, rs1_busy, rs2_busy, wb_ready} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0",
               {rf_en_write, rf_reg_w, byp1_hit, byp2_hit, rs1_busy, rs2_busy, wb_ready});
    end
    checks++;
    if ({rf_data_in, byp1_data, byp2_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h want 0", rf_data_in, byp1_data, byp2_data);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    // Traffic in flight, then asynchronous reset between edges.
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_rd = 5'd4;
    step();
    iss_valid = 1'b0;
    set_req(0, 5'd3, 64'h3333);
    sb_push(5'd3, 64'h3333);
    rs1 = 5'd4; rs2 = 5'd3;
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy got %b%b want 11", rs1_busy, rs2_busy);
    end
    step();
    idle();
    checks++;
    if (rf_en_write !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_commit got %b want 1", rf_en_write);
    end
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({rf_en_write, rf_reg_w, rs1_busy, rs2_busy} !== '0 || rf_data_in !== '0) begin
      errors++;
      $display("FAIL reset_midflight got en=%b rd=%0d busy=%b%b data=%h want 0",
               rf_en_write, rf_reg_w, rs1_busy, rs2_busy, rf_data_in);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || rf_en_write !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got busy=%b%b en=%b want 000", rs1_busy, rs2_busy, rf_en_write);
    end
    step();
  endtask

  task automatic test_single_write();
    rs1 = 5'd5; rs2 = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL sw_issue got %b want 1", iss_ready);
    end
    step();
    iss_valid = 1'b0;
    set_req(0, 5'd5, 64'hDEADBEEF_CAFEF00D);
    sb_push(5'd5, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    checks++;
    if (wb_ready !== 3'b001 || rs1_busy !== 1'b1) begin
      errors++; $display("FAIL sw_grant got ready=%b busy=%b want 001 1", wb_ready, rs1_busy);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
`ifdef RF_WB_BYPASS_EN
    if (rf_en_write !== 1'b1 || rs1_busy !== 1'b0 || byp1_hit !== 1'b1 ||
        byp1_data !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL sw_commit got en=%b busy=%b hit=%b data=%h want 1 0 1 deadbeefcafef00d",
               rf_en_write, rs1_busy, byp1_hit, byp1_data);
    end
`else
    if (rf_en_write !== 1'b1 || rs1_busy !== 1'b1 || byp1_hit !== 1'b0) begin
      errors++;
      $display("FAIL sw_commit got en=%b busy=%b hit=%b want 1 1 0", rf_en_write, rs1_busy, byp1_hit);
    end
`endif
    step();
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b0 || rf_en_write !== 1'b0) begin
      errors++; $display("FAIL sw_clear got busy=%b en=%b want 0 0", rs1_busy, rf_en_write);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sw_drain got %0d pending want 0", sb.size());
    end
    step();
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 0, 2, 0};
    logic [NREQ-1:0] want;
    logic [XLEN-1:0] d;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        if (c < 3 || k != 1) begin
          d = 64'hA000 + 64'(c * 16 + k);
          set_req(k, 5'(10 + k), d);
        end
      end
      d = 64'hA000 + 64'(c * 16 + exp_seq[c]);
      sb_push(5'(10 + exp_seq[c]), d);
      want = NREQ'(1) << exp_seq[c];
      @(negedge clk);
      checks++;
      if (wb_ready !== want) begin
        errors++; $display("FAIL rr_grant%0d got %b want %b", c, wb_ready, want);
      end
      step();
    end
    idle();
    step();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rr_drain got %0d pending want 0", sb.size());
    end
    step();
  endtask

  task automatic test_x0();
    iss_valid = 1'b1; iss_rd = 5'd0;
    set_req(1, 5'd0, '1);
    @(negedge clk);
    checks++;
    if (wb_ready !== 3'b010 || iss_ready !== 1'b1) begin
      errors++; $display("FAIL x0_grant got ready=%b iss=%b want 010 1", wb_ready, iss_ready);
    end
    step();
    idle();
    rs1 = 5'd0;
    @(negedge clk);
    checks++;
    if (rf_en_write !== 1'b0 || rs1_busy !== 1'b0 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_commit got en=%b busy=%b iss=%b want 0 0 1", rf_en_write, rs1_busy, iss_ready);
    end
    step();
  endtask

  task automatic test_waw();
    rs1 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL waw_first got %b want 1", iss_ready);
    end
    step();
    set_req(2, 5'd7, 64'h7777);
    sb_push(5'd7, 64'h7777);
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b0 || wb_ready !== 3'b100) begin
      errors++; $display("FAIL waw_block got iss=%b ready=%b want 0 100", iss_ready, wb_ready);
    end
    step();
    idle();
    step();
    set_req(0, 5'd7, 64'h7000);
    sb_push(5'd7, 64'h7000);
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b0 || wb_ready !== 3'b001) begin
      errors++; $display("FAIL waw_cleared got busy=%b ready=%b want 0 001", rs1_busy, wb_ready);
    end
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1 || rf_en_write !== 1'b1) begin
      errors++; $display("FAIL waw_same_cycle got iss=%b en=%b want 1 1", iss_ready, rf_en_write);
    end
    step();
    iss_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b1 || iss_ready !== 1'b0) begin
      errors++; $display("FAIL waw_set_wins got busy=%b iss=%b want 1 0", rs1_busy, iss_ready);
    end
    set_req(1, 5'd7, 64'h7111);
    sb_push(5'd7, 64'h7111);
    step();
    idle();
    step();
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL waw_drain got pending=%0d busy=%b want 0 0", sb.size(), rs1_busy);
    end
    step();
  endtask

  task automatic test_bypass();
    rs1 = 5'd8; rs2 = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    set_req(0, 5'd9, 64'h1234);
    sb_push(5'd9, 64'h1234);
    step();
    idle();
    @(negedge clk);
    checks++;
`ifdef RF_WB_BYPASS_EN
    if (byp2_hit !== 1'b1 || byp2_data !== 64'h1234 || rs2_busy !== 1'b0 || byp1_hit !== 1'b0) begin
      errors++;
      $display("FAIL bypass got hit2=%b data2=%h busy2=%b hit1=%b want 1 1234 0 0",
               byp2_hit, byp2_data, rs2_busy, byp1_hit);
    end
`else
    if (byp2_hit !== 1'b0 || byp2_data !== '0 || rs2_busy !== 1'b1 || byp1_hit !== 1'b0) begin
      errors++;
      $display("FAIL bypass got hit2=%b data2=%h busy2=%b hit1=%b want 0 0 1 0",
               byp2_hit, byp2_data, rs2_busy, byp1_hit);
    end
`endif
    step();
    @(negedge clk);
    checks++;
    if (rs2_busy !== 1'b0 || byp2_hit !== 1'b0) begin
      errors++; $display("FAIL bypass_after got busy2=%b hit2=%b want 0 0", rs2_busy, byp2_hit);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int m_ptr;
    int win;
    int idx;
    logic [NREQ-1:0] want;
    logic [REG_AW-1:0] rds[NREQ];
    logic [XLEN-1:0] ds[NREQ];
    do_reset();
    m_ptr = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      for (int k = 0; k < NREQ; k++) begin
        rds[k] = 5'($urandom_range(0, 31));
        ds[k]  = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) set_req(k, rds[k], ds[k]);
      end
      win = -1;
      for (int i = 0; i < NREQ; i++) begin
        idx = (m_ptr + i) % NREQ;
        if (win < 0 && wb_valid[idx]) win = idx;
      end
      want = '0;
      if (win >= 0) begin
        want[win] = 1'b1;
        sb_push(rds[win], ds[win]);
        m_ptr = (win + 1) % NREQ;
      end
      @(negedge clk);
      checks++;
      if (wb_ready !== want) begin
        errors++; $display("FAIL b2b_grant%0d got %b want %b", c, wb_ready, want);
      end
      step();
    end
    idle();
    step();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain got %0d pending want 0", sb.size());
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0();
    test_waw();
    test_bypass();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
